card_board: RTL and testbench

Card-board responder for the memory game: holds the per-card state and colour for the 12 playing cards (6 pairs) and executes the game controller's card-write commands. While the controller requests a click, it hit-tests left-button presses against the on-screen card grid and returns one `card_pressed` pulse with the address and colour of the clicked covered card. It also keeps a display snapshot of the board, refreshed only when the controller asks for a card update, and a registered colour read port for the renderer.

---
 rtl/card_board.sv | 187 ++++++++++++++++++
 tb/tb_card_board.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_board.sv
// Card-board responder for the memory game: card state/colour storage, click hit-testing
// against the on-screen grid, display snapshot and registered colour read port.
module card_board #(
    parameter int GRID_X0 = 112,
    parameter int GRID_Y0 = 84,
    parameter int CARD_W  = 160,
    parameter int CARD_H  = 160,
    parameter int GAP     = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        board_init,
    input  logic        color_wr_en,
    input  logic [3:0]  color_wr_addr,
    input  logic [11:0] color_wr_data,
    input  logic        write_card_en,
    input  logic [3:0]  write_card_address,
    input  logic [1:0]  write_card_state,
    input  logic        update_cards_en,
    input  logic        wait_for_click_en,
    input  logic        mouse_left,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic [3:0]  disp_addr,
    output logic        card_pressed,
    output logic [3:0]  card_clicked_address,
    output logic [11:0] card_clicked_color,
    output logic [23:0] card_state_disp,
    output logic [11:0] disp_color
);
    localparam int N_CARDS = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_RESPOND = 2'd2
    } click_state_t;

    logic [1:0]   card_state_r [N_CARDS];
    logic [11:0]  card_color_r [N_CARDS];
    click_state_t click_state_r;
    click_state_t click_state_next_s;
    logic [3:0]   idx_r;
    logic [3:0]   idx_next_s;
    logic [11:0]  cap_x_r;
    logic [11:0]  cap_y_r;
    logic         mouse_prev_r;
    logic         press_s;
    logic         hit_s;
    logic         covered_s;
    logic         capture_s;
    logic         latch_s;
    logic [23:0]  live_packed_s;
    logic         card_pressed_r;
    logic [3:0]   card_clicked_address_r;
    logic [11:0]  card_clicked_color_r;
    logic [23:0]  card_state_disp_r;
    logic [11:0]  disp_color_r;

    // Card idx occupies column idx[1:0], row idx[3:2]; bounds are half-open intervals.
    function automatic logic card_hit(input logic [3:0] idx, input logic [11:0] x,
                                      input logic [11:0] y);
        logic [11:0] x_lo;
        logic [11:0] y_lo;
        x_lo = 12'(GRID_X0 + int'(idx[1:0]) * (CARD_W + GAP));
        y_lo = 12'(GRID_Y0 + int'(idx[3:2]) * (CARD_H + GAP));
        return (x >= x_lo) && (x < 12'(x_lo + 12'(CARD_W))) &&
               (y >= y_lo) && (y < 12'(y_lo + 12'(CARD_H)));
    endfunction

    // Card-state array: init overrides any single-card write in the same cycle
    always_ff @(posedge clk) begin
        if (rst || board_init) begin
            for (int i = 0; i < N_CARDS; i++) card_state_r[i] <= 2'b01;
        end else if (write_card_en && (write_card_address < 4'd12)) begin
            card_state_r[write_card_address] <= write_card_state;
        end
    end

    // Card-colour array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CARDS; i++) card_color_r[i] <= 12'h000;
        end else if (color_wr_en && (color_wr_addr < 4'd12)) begin
            card_color_r[color_wr_addr] <= color_wr_data;
        end
    end

    // Press edge detect, hit test of the current scan card, live state packing
    always_comb begin
        press_s       = mouse_left & ~mouse_prev_r;
        hit_s         = 1'b0;
        covered_s     = 1'b0;
        live_packed_s = 24'h000000;
        if (idx_r < 4'd12) begin
            hit_s     = card_hit(idx_r, cap_x_r, cap_y_r);
            covered_s = (card_state_r[idx_r] == 2'b01);
        end else begin
            hit_s     = 1'b0;
            covered_s = 1'b0;
        end
        for (int i = 0; i < N_CARDS; i++) live_packed_s[2*i +: 2] = card_state_r[i];
    end

    // Click FSM next-state logic
    always_comb begin
        click_state_next_s = click_state_r;
        idx_next_s         = idx_r;
        capture_s          = 1'b0;
        latch_s            = 1'b0;
        case (click_state_r)
            ST_IDLE: begin
                if (press_s && wait_for_click_en) begin
                    click_state_next_s = ST_SCAN;
                    idx_next_s         = 4'd0;
                    capture_s          = 1'b1;
                end else begin
                    click_state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // Losing the click window beats any hit found this cycle
                if (!wait_for_click_en) begin
                    click_state_next_s = ST_IDLE;
                end else if (hit_s) begin
                    if (covered_s) begin
                        latch_s            = 1'b1;
                        click_state_next_s = ST_RESPOND;
                    end else begin
                        click_state_next_s = ST_IDLE;
                    end
                end else if (idx_r == 4'd11) begin
                    click_state_next_s = ST_IDLE;
                end else begin
                    idx_next_s = idx_r + 4'd1;
                end
            end
            ST_RESPOND: click_state_next_s = ST_IDLE;
            default:    click_state_next_s = ST_IDLE;
        endcase
    end

    // Click FSM registers and captured cursor position
    always_ff @(posedge clk) begin
        if (rst) begin
            click_state_r <= ST_IDLE;
            idx_r         <= 4'd0;
            cap_x_r       <= 12'd0;
            cap_y_r       <= 12'd0;
            mouse_prev_r  <= 1'b0;
        end else begin
            click_state_r <= click_state_next_s;
            idx_r         <= idx_next_s;
            mouse_prev_r  <= mouse_left;
            if (capture_s) begin
                cap_x_r <= mouse_x;
                cap_y_r <= mouse_y;
            end
        end
    end

    // Registered outputs: click result, display snapshot, renderer colour read
    always_ff @(posedge clk) begin
        if (rst) begin
            card_pressed_r         <= 1'b0;
            card_clicked_address_r <= 4'd0;
            card_clicked_color_r   <= 12'h000;
            card_state_disp_r      <= 24'h555555;
            disp_color_r           <= 12'h000;
        end else begin
            card_pressed_r <= (click_state_r == ST_RESPOND);
            if (latch_s) begin
                card_clicked_address_r <= idx_r;
                card_clicked_color_r   <= card_color_r[idx_r];
            end
            if (update_cards_en) card_state_disp_r <= live_packed_s;
            disp_color_r <= (disp_addr < 4'd12) ? card_color_r[disp_addr] : 12'h000;
        end
    end

    assign card_pressed         = card_pressed_r;
    assign card_clicked_address = card_clicked_address_r;
    assign card_clicked_color   = card_clicked_color_r;
    assign card_state_disp      = card_state_disp_r;
    assign disp_color           = disp_color_r;

endmodule

// File: tb/tb_card_board.sv
// Directed self-checking bench for card_board: one task per scenario, expected
// values hand-computed from the card grid geometry and reset defaults.
module tb_card_board;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        board_init = 1'b0;
    logic        color_wr_en = 1'b0;
    logic [3:0]  color_wr_addr = 4'd0;
    logic [11:0] color_wr_data = 12'h000;
    logic        write_card_en = 1'b0;
    logic [3:0]  write_card_address = 4'd0;
    logic [1:0]  write_card_state = 2'b00;
    logic        update_cards_en = 1'b0;
    logic        wait_for_click_en = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_x = 12'd0;
    logic [11:0] mouse_y = 12'd0;
    logic [3:0]  disp_addr = 4'd0;
    logic        card_pressed;
    logic [3:0]  card_clicked_address;
    logic [11:0] card_clicked_color;
    logic [23:0] card_state_disp;
    logic [11:0] disp_color;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    card_board dut (
        .clk(clk), .rst(rst), .board_init(board_init),
        .color_wr_en(color_wr_en), .color_wr_addr(color_wr_addr), .color_wr_data(color_wr_data),
        .write_card_en(write_card_en), .write_card_address(write_card_address),
        .write_card_state(write_card_state), .update_cards_en(update_cards_en),
        .wait_for_click_en(wait_for_click_en), .mouse_left(mouse_left),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .disp_addr(disp_addr),
        .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
        .card_clicked_color(card_clicked_color), .card_state_disp(card_state_disp),
        .disp_color(disp_color)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_state(input logic [3:0] a, input logic [1:0] s);
        write_card_en = 1'b1; write_card_address = a; write_card_state = s;
        tick();
        write_card_en = 1'b0;
    endtask

    task automatic write_color(input logic [3:0] a, input logic [11:0] c);
        color_wr_en = 1'b1; color_wr_addr = a; color_wr_data = c;
        tick();
        color_wr_en = 1'b0;
    endtask

    task automatic update_snapshot();
        update_cards_en = 1'b1;
        tick();
        update_cards_en = 1'b0;
    endtask

    // Press and hold; lat counts cycles from the press-sampling edge to the first pulse.
    task automatic click(input logic [11:0] x, input logic [11:0] y, input int hold,
                         output int lat, output int pulses,
                         output logic [3:0] addr, output logic [11:0] col);
        lat = -1; pulses = 0; addr = 4'd0; col = 12'h000;
        mouse_x = x; mouse_y = y; mouse_left = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (card_pressed) begin
                pulses++;
                if (lat < 0) begin
                    lat = i - 1; addr = card_clicked_address; col = card_clicked_color;
                end
            end
        end
        mouse_left = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if (card_state_disp !== 24'h555555) begin
            n_fail++; $display("FAIL reset_disp: got %h expected 555555", card_state_disp);
        end
        n_checks++;
        if (card_pressed !== 1'b0 || card_clicked_address !== 4'd0 || card_clicked_color !== 12'h000) begin
            n_fail++; $display("FAIL reset_click: got %b/%0d/%h expected 0/0/000",
                               card_pressed, card_clicked_address, card_clicked_color);
        end
        for (int a = 0; a < 16; a++) begin
            disp_addr = 4'(a);
            tick();
            n_checks++;
            if (disp_color !== 12'h000) begin
                n_fail++; $display("FAIL reset_color[%0d]: got %h expected 000", a, disp_color);
            end
        end
    endtask

    task automatic test_color_hit();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        write_color(4'd5, 12'hF00);
        disp_addr = 4'd5;
        tick();
        n_checks++;
        if (disp_color !== 12'hF00) begin
            n_fail++; $display("FAIL read_color5: got %h expected f00", disp_color);
        end
        wait_for_click_en = 1'b1;
        click(12'd312, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (lat !== 7 || pulses !== 1) begin
            n_fail++; $display("FAIL hit5_timing: got lat %0d pulses %0d expected 7 1", lat, pulses);
        end
        n_checks++;
        if (addr !== 4'd5 || col !== 12'hF00) begin
            n_fail++; $display("FAIL hit5_data: got %0d %h expected 5 f00", addr, col);
        end
        n_checks++;
        if (card_clicked_address !== 4'd5 || card_clicked_color !== 12'hF00) begin
            n_fail++; $display("FAIL hit5_hold: got %0d %h expected 5 f00",
                               card_clicked_address, card_clicked_color);
        end
    endtask

    task automatic test_latency();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        click(12'd112, 12'd84, 20, lat, pulses, addr, col);
        n_checks++;
        if (lat !== 2 || pulses !== 1 || addr !== 4'd0) begin
            n_fail++; $display("FAIL hit0: got lat %0d pulses %0d addr %0d expected 2 1 0", lat, pulses, addr);
        end
        // Card 11 lower-right corner pixel (col 3, row 2)
        click(12'd871, 12'd643, 20, lat, pulses, addr, col);
        n_checks++;
        if (lat !== 13 || pulses !== 1 || addr !== 4'd11) begin
            n_fail++; $display("FAIL hit11: got lat %0d pulses %0d addr %0d expected 13 1 11", lat, pulses, addr);
        end
    endtask

    task automatic test_miss();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        click(12'd272, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL miss_gap: got %0d pulses expected 0", pulses);
        end
        click(12'd311, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL miss_edge: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_non_covered();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        write_state(4'd5, 2'b11);
        click(12'd312, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL discovered_click: got %0d pulses expected 0", pulses);
        end
        write_state(4'd5, 2'b10);
        click(12'd312, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL deactivated_click: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_snapshot_init();
        write_state(4'd0, 2'b10);
        tick(); tick(); tick();
        n_checks++;
        if (card_state_disp !== 24'h555555) begin
            n_fail++; $display("FAIL snap_stale: got %h expected 555555", card_state_disp);
        end
        update_snapshot();
        n_checks++;
        if (card_state_disp !== 24'h555956) begin
            n_fail++; $display("FAIL snap_update: got %h expected 555956", card_state_disp);
        end
        // State write coinciding with the update must not appear yet
        write_card_en = 1'b1; write_card_address = 4'd1; write_card_state = 2'b11;
        update_cards_en = 1'b1;
        tick();
        write_card_en = 1'b0; update_cards_en = 1'b0;
        n_checks++;
        if (card_state_disp !== 24'h555956) begin
            n_fail++; $display("FAIL snap_same_cycle: got %h expected 555956", card_state_disp);
        end
        update_snapshot();
        n_checks++;
        if (card_state_disp !== 24'h55595E) begin
            n_fail++; $display("FAIL snap_next: got %h expected 55595e", card_state_disp);
        end
        board_init = 1'b1;
        write_card_en = 1'b1; write_card_address = 4'd2; write_card_state = 2'b11;
        tick();
        board_init = 1'b0; write_card_en = 1'b0;
        update_snapshot();
        n_checks++;
        if (card_state_disp !== 24'h555555) begin
            n_fail++; $display("FAIL init_priority: got %h expected 555555", card_state_disp);
        end
    endtask

    task automatic test_back_to_back();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        write_color(4'd6, 12'h0F0);
        click(12'd312, 12'd284, 12, lat, pulses, addr, col);
        wait_for_click_en = 1'b0;
        tick();
        wait_for_click_en = 1'b1;
        click(12'd512, 12'd284, 20, lat, pulses, addr, col);
        n_checks++;
        if (lat !== 8 || pulses !== 1 || addr !== 4'd6 || col !== 12'h0F0) begin
            n_fail++; $display("FAIL b2b_card6: got lat %0d pulses %0d addr %0d col %h expected 8 1 6 0f0",
                               lat, pulses, addr, col);
        end
    endtask

    task automatic test_edge_rules();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        click(12'd312, 12'd284, 40, lat, pulses, addr, col);
        n_checks++;
        if (pulses !== 1 || lat !== 7) begin
            n_fail++; $display("FAIL held_button: got %0d pulses lat %0d expected 1 7", pulses, lat);
        end
        wait_for_click_en = 1'b0;
        click(12'd112, 12'd84, 20, lat, pulses, addr, col);
        wait_for_click_en = 1'b1;
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL no_wait_press: got %0d pulses expected 0", pulses);
        end
        // Withdraw the click window on the edge that scans card 11
        pulses = 0;
        mouse_x = 12'd712; mouse_y = 12'd484; mouse_left = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            if (i == 13) wait_for_click_en = 1'b0;
            tick();
            if (card_pressed) pulses++;
        end
        mouse_left = 1'b0;
        tick();
        wait_for_click_en = 1'b1;
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL drop_wait_scan: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, pulses; logic [3:0] addr; logic [11:0] col;
        pulses = 0;
        mouse_x = 12'd712; mouse_y = 12'd484; mouse_left = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        rst = 1'b1; mouse_left = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (card_clicked_address !== 4'd0 || card_clicked_color !== 12'h000) begin
            n_fail++; $display("FAIL rst_outputs: got %0d %h expected 0 000",
                               card_clicked_address, card_clicked_color);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (card_pressed) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL rst_mid_scan: got %0d pulses expected 0", pulses);
        end
        click(12'd112, 12'd84, 20, lat, pulses, addr, col);
        n_checks++;
        if (lat !== 2 || pulses !== 1 || addr !== 4'd0 || col !== 12'h000) begin
            n_fail++; $display("FAIL rst_idle_click: got lat %0d pulses %0d addr %0d col %h expected 2 1 0 000",
                               lat, pulses, addr, col);
        end
    endtask

    task automatic test_address_bounds();
        color_wr_en = 1'b1; color_wr_addr = 4'd13; color_wr_data = 12'hABC;
        write_card_en = 1'b1; write_card_address = 4'd13; write_card_state = 2'b10;
        tick();
        color_wr_en = 1'b0; write_card_en = 1'b0;
        disp_addr = 4'd13;
        tick();
        n_checks++;
        if (disp_color !== 12'h000) begin
            n_fail++; $display("FAIL oob_read13: got %h expected 000", disp_color);
        end
        for (int a = 0; a < 12; a++) begin
            disp_addr = 4'(a);
            tick();
            n_checks++;
            if (disp_color !== 12'h000) begin
                n_fail++; $display("FAIL oob_color[%0d]: got %h expected 000", a, disp_color);
            end
        end
        update_snapshot();
        n_checks++;
        if (card_state_disp !== 24'h555555) begin
            n_fail++; $display("FAIL oob_state: got %h expected 555555", card_state_disp);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_color_hit();
        test_latency();
        test_miss();
        test_non_covered();
        test_snapshot_init();
        test_back_to_back();
        test_edge_rules();
        test_reset_mid_scan();
        test_address_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
